aq_fadd_vec_seq: RTL and testbench
==================================

Name: aq_fadd_vec_seq

Overview:
Sequencer for the vector FADD datapath (64-bit SIMD adder and ex2 round stage). It accepts one vector add/sub request and splits it into 64-bit beats. It issues each beat to ex1 with a per-lane element mask, drives the one-hot rounding-mode controls into ex2, and applies writeback backpressure to the two-stage pipe. It also accumulates the inexact flag and signals completion. It sits between the vector issue queue and the vfalu fadd datapath.

Parameters:
VLEN, 256, vector register width in bits.
DP_W, 64, datapath width per beat; beats per full vector = VLEN/DP_W = 4.

Ports:
forever_cpuclk  in  1  clock
vfalu_rst  in  1  synchronous active-high reset
req_vld  in  1  request valid
req_rdy  out  1  request accepted when req_vld&req_rdy
req_sew  in  2  format: 00 bf16, 01 half, 10 single, 11 double
req_vl  in  5  element count 0..16
req_rm  in  3  static rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 illegal
flush  in  1  synchronous kill
ex1_issue_vld  out  1  beat presented to ex1
ex1_beat_idx  out  2  beat number
ex1_elem_mask  out  4  lane enables (lane0 = LSB; double uses bit0, single uses bits1:0)
ex1_fmt  out  2  latched sew
ex2_rne, ex2_rtz, ex2_rdn, ex2_rup, ex2_rmm  out  1 each  one-hot rounding controls
ex2_nx  in  4  per-lane inexact from datapath, valid when wb_vld
wb_vld  out  1  ex2 beat result valid
wb_beat_idx  out  2  beat number at ex2
wb_last  out  1  final beat of request
wb_rdy  in  1  writeback accepts beat
pipe_stall  out  1  ~wb_rdy & wb_vld; freezes ex1/ex2 datapath registers
busy  out  1  state != IDLE
done_vld  out  1  one-cycle completion pulse
done_nx  out  1  OR of masked nx over all beats
done_ill  out  1  illegal rm, no beats issued

Behaviour:
- Reset: FSM in IDLE; all valids, masks, indices, rounding one-hots, done_* and pipe_stall are 0; req_rdy = 1.
- FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE: req_rdy = ~flush. On accept, latch sew, rm and vl. If vl > VLEN/elem_bits, clamp to that maximum (double 4, single 8, half/bf16 16).
  - Illegal rm or vl = 0: go to DONE. done_ill = 1 for illegal rm; done_nx = 0.
  - Otherwise go to ISSUE. nbeats = ceil(vl/lanes); lanes = 1/2/4 for double/single/16-bit.
- ISSUE: ex1_issue_vld = 1 from the cycle after accept. The beat advances when ~pipe_stall. ex1_elem_mask = all lanes of the format, except the last beat, which gets (1<<(vl - idx*lanes)) - 1. After the last beat advances, go to DRAIN.
- Pipe: ex1 valid moves to the ex2 register (wb_vld) when ~pipe_stall. wb_vld holds with stable idx/mask while ~wb_rdy. wb_last = wb_vld & (wb_beat_idx == nbeats-1).
- Accumulate nx on each wb_vld&wb_rdy: acc |= |(ex2_nx & wb_mask).
- DRAIN: wait for the last beat's wb handshake, then go to DONE.
- DONE: one cycle. done_vld = 1; done_nx = acc including the final beat. Then IDLE with acc cleared.
- Latency, no stall: accept cycle 0, first ex1 cycle 1, first wb cycle 2, last wb cycle nbeats+1, done_vld cycle nbeats+2.
- ex2_r* = one-hot of latched rm while busy with legal rm; 0 in IDLE.
- Flush, any state: next cycle IDLE, all valids 0, acc cleared, no done_vld.
  - Flush beats a same-cycle req_vld.
  - Flush beats a same-cycle wb handshake; wb_rdy is ignored in that cycle.
- No new request is accepted until the DONE→IDLE transition. Back-to-back requests are separated by one bubble minimum.

Decomposition:
- Shared package: SEW encodings, RM encodings, RM_ILLEGAL range, a lanes-per-format constant table, BEAT_W = clog2(VLEN/DP_W).
- One sub-module, aq_fadd_rm_dec: combinational rm → one-hot plus illegal flag, reused by the fma sequencer.
- FSM, beat counter, mask generation, 2-entry valid pipe and nx accumulator stay in the top module.

Test Plan:
1. Double, vl=3, rm=0, wb_rdy=1.
   - ex1 beats 0,1,2 on cycles 1-3, each mask 0001; wb_last on cycle 4.
   - ex2_nx=0001 on beat 1 only → done_vld cycle 5 with done_nx=1; ex2_rne=1 throughout busy.
2. Half, vl=6, rm=4.
   - Two beats with masks 1111 then 0011; ex2_rmm=1.
   - ex2_nx=1100 on beat 1 (masked lanes) → done_nx=0.
3. Single, vl=8, wb_rdy low cycles 3-5.
   - pipe_stall=1 in cycles 3-5; wb_beat_idx and ex1_beat_idx frozen; no beat lost or duplicated.
   - done_vld 3 cycles later than unstalled.
4. Flush asserted in cycle 2 of a double vl=4 request.
   - Cycle 3: busy=0, wb_vld=0, no done_vld.
   - A new request accepted in cycle 3 runs cleanly with acc=0.
5. vl=0, rm=1 → done_vld next cycle, done_nx=0, done_ill=0, ex1_issue_vld never set.
   - rm=6 → done_ill=1, all ex2_r* = 0.
6. Reset asserted mid-ISSUE with req_vld high → the following cycle has all outputs 0, req_rdy=1 and state IDLE; the request is accepted only after reset deasserts.

Source files
------------

// File: rtl/aq_fadd_vec_seq_pkg.sv
// Shared encodings and per-format tables for the vector FADD sequencer
// and its sibling sequencers.
package aq_fadd_vec_seq_pkg;

    localparam int VLEN   = 256;
    localparam int DP_W   = 64;
    localparam int NBEATS = VLEN / DP_W;
    localparam int BEAT_W = $clog2(NBEATS);

    typedef enum logic [1:0] {
        SEW_BF16   = 2'b00,
        SEW_HALF   = 2'b01,
        SEW_SINGLE = 2'b10,
        SEW_DOUBLE = 2'b11
    } sew_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    // Encodings at or above this value have no rounding behaviour defined.
    localparam logic [2:0] RM_ILLEGAL_MIN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Indexed by sew: bf16, half, single, double.
    localparam logic [3:0][2:0] LANES  = {3'd1, 3'd2, 3'd4, 3'd4};
    localparam logic [3:0][4:0] MAX_VL = {5'd4, 5'd8, 5'd16, 5'd16};

    function automatic logic [3:0] fullMask(input logic [1:0] sew);
        logic [4:0] ones;
        ones = (5'd1 << LANES[sew]) - 5'd1;
        return ones[3:0];
    endfunction

endpackage

// File: rtl/aq_fadd_rm_dec.sv
// Static rounding-mode decoder: one-hot controls {rmm,rup,rdn,rtz,rne}
// plus an illegal flag; the one-hot is all zero for illegal encodings.
module aq_fadd_rm_dec
    import aq_fadd_vec_seq_pkg::*;
(
    input  logic [2:0] rm_i,
    output logic [4:0] onehot_o,
    output logic       illegal_o
);

    always_comb begin
        onehot_o  = 5'b00000;
        illegal_o = 1'b0;
        case (rm_i)
            RM_RNE:  onehot_o = 5'b00001;
            RM_RTZ:  onehot_o = 5'b00010;
            RM_RDN:  onehot_o = 5'b00100;
            RM_RUP:  onehot_o = 5'b01000;
            RM_RMM:  onehot_o = 5'b10000;
            default: illegal_o = (rm_i >= RM_ILLEGAL_MIN);
        endcase
    end

endmodule

// File: rtl/aq_fadd_vec_seq.sv
// Vector FADD sequencer: splits one vector add/sub into 64-bit beats,
// runs a two-entry valid pipe to writeback and accumulates inexact.
module aq_fadd_vec_seq
    import aq_fadd_vec_seq_pkg::*;
(
    input  logic       forever_cpuclk,
    input  logic       vfalu_rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic [1:0] req_sew,
    input  logic [4:0] req_vl,
    input  logic [2:0] req_rm,
    input  logic       flush,
    output logic       ex1_issue_vld,
    output logic [1:0] ex1_beat_idx,
    output logic [3:0] ex1_elem_mask,
    output logic [1:0] ex1_fmt,
    output logic       ex2_rne,
    output logic       ex2_rtz,
    output logic       ex2_rdn,
    output logic       ex2_rup,
    output logic       ex2_rmm,
    input  logic [3:0] ex2_nx,
    output logic       wb_vld,
    output logic [1:0] wb_beat_idx,
    output logic       wb_last,
    input  logic       wb_rdy,
    output logic       pipe_stall,
    output logic       busy,
    output logic       done_vld,
    output logic       done_nx,
    output logic       done_ill
);

    state_e              state_q, state_d;
    logic [1:0]          sew_q, sew_d;
    logic [2:0]          rm_q, rm_d;
    logic [4:0]          vl_q, vl_d;
    logic [BEAT_W-1:0]   lastIdx_q, lastIdx_d;
    logic [BEAT_W-1:0]   ex1Idx_q, ex1Idx_d;
    logic                wbVld_q, wbVld_d;
    logic [BEAT_W-1:0]   wbIdx_q, wbIdx_d;
    logic [3:0]          wbMask_q, wbMask_d;
    logic                acc_q, acc_d;
    logic                ill_q, ill_d;

    logic                accept;
    logic [2:0]          rmSel;
    logic [4:0]          rmOneHot;
    logic                rmIll;
    logic [4:0]          vlClamp;
    logic [4:0]          nbeatsNew;
    logic [4:0]          beatBase;
    logic [4:0]          remElems;
    logic [4:0]          lastOnes;
    logic [3:0]          ex1Mask;
    logic                ex1IsLast;
    logic                wbHandshake;

    // In IDLE the decoder checks the incoming request; otherwise it
    // drives the latched mode onto the ex2 controls.
    assign rmSel = (state_q == ST_IDLE) ? req_rm : rm_q;

    aq_fadd_rm_dec u_rm_dec (
        .rm_i      (rmSel),
        .onehot_o  (rmOneHot),
        .illegal_o (rmIll)
    );

    assign accept      = (state_q == ST_IDLE) && req_vld && !flush;
    assign pipe_stall  = wbVld_q && !wb_rdy;
    assign wbHandshake = wbVld_q && wb_rdy;

    assign vlClamp = (req_vl > MAX_VL[req_sew]) ? MAX_VL[req_sew] : req_vl;

    always_comb begin
        nbeatsNew = vlClamp;
        case (req_sew)
            SEW_DOUBLE: nbeatsNew = vlClamp;
            SEW_SINGLE: nbeatsNew = (vlClamp + 5'd1) >> 1;
            default:    nbeatsNew = (vlClamp + 5'd3) >> 2;
        endcase
    end

    // Only the final beat can be partial; its remainder is 1..lanes.
    assign beatBase  = 5'(ex1Idx_q) * 5'(LANES[sew_q]);
    assign remElems  = vl_q - beatBase;
    assign lastOnes  = (5'd1 << remElems) - 5'd1;
    assign ex1IsLast = (ex1Idx_q == lastIdx_q);
    assign ex1Mask   = ex1IsLast ? lastOnes[3:0] : fullMask(sew_q);

    always_ff @(posedge forever_cpuclk) begin
        if (vfalu_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (rmIll || vlClamp == 5'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!pipe_stall && ex1IsLast) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wbHandshake && wbIdx_q == lastIdx_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        req_rdy       = (state_q == ST_IDLE) && !flush;
        busy          = (state_q != ST_IDLE);
        ex1_issue_vld = (state_q == ST_ISSUE);
        ex1_beat_idx  = ex1_issue_vld ? ex1Idx_q : '0;
        ex1_elem_mask = ex1_issue_vld ? ex1Mask : 4'b0000;
        ex1_fmt       = sew_q;
        wb_vld        = wbVld_q;
        wb_beat_idx   = wbVld_q ? wbIdx_q : '0;
        wb_last       = wbVld_q && (wbIdx_q == lastIdx_q);
        done_vld      = (state_q == ST_DONE);
        done_nx       = done_vld && acc_q;
        done_ill      = done_vld && ill_q;
        {ex2_rmm, ex2_rup, ex2_rdn, ex2_rtz, ex2_rne} =
            (busy && !rmIll) ? rmOneHot : 5'b00000;
    end

    // Beat pipe and inexact accumulator; a flush discards everything,
    // including a writeback handshake in the same cycle.
    always_comb begin
        sew_d     = sew_q;
        rm_d      = rm_q;
        vl_d      = vl_q;
        lastIdx_d = lastIdx_q;
        ex1Idx_d  = ex1Idx_q;
        wbVld_d   = wbVld_q;
        wbIdx_d   = wbIdx_q;
        wbMask_d  = wbMask_q;
        acc_d     = acc_q;
        ill_d     = ill_q;

        if (accept) begin
            sew_d     = req_sew;
            rm_d      = req_rm;
            vl_d      = vlClamp;
            lastIdx_d = BEAT_W'(nbeatsNew - 5'd1);
            ex1Idx_d  = '0;
            ill_d     = rmIll;
            acc_d     = 1'b0;
        end

        if (!pipe_stall) begin
            wbVld_d = (state_q == ST_ISSUE);
            if (state_q == ST_ISSUE) begin
                wbIdx_d  = ex1Idx_q;
                wbMask_d = ex1Mask;
                ex1Idx_d = ex1Idx_q + BEAT_W'(1);
            end
        end

        if (wbHandshake) acc_d = acc_q | (|(ex2_nx & wbMask_q));
        if (state_q == ST_DONE) acc_d = 1'b0;

        if (flush) begin
            wbVld_d = 1'b0;
            acc_d   = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (vfalu_rst) begin
            sew_q     <= '0;
            rm_q      <= '0;
            vl_q      <= '0;
            lastIdx_q <= '0;
            ex1Idx_q  <= '0;
            wbVld_q   <= 1'b0;
            wbIdx_q   <= '0;
            wbMask_q  <= '0;
            acc_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            sew_q     <= sew_d;
            rm_q      <= rm_d;
            vl_q      <= vl_d;
            lastIdx_q <= lastIdx_d;
            ex1Idx_q  <= ex1Idx_d;
            wbVld_q   <= wbVld_d;
            wbIdx_q   <= wbIdx_d;
            wbMask_q  <= wbMask_d;
            acc_q     <= acc_d;
            ill_q     <= ill_d;
        end
    end

endmodule

// File: tb/tb_aq_fadd_vec_seq.sv
// Directed bench for aq_fadd_vec_seq: hand-computed beat schedules,
// masks, stall, flush, illegal-rm and reset scenarios.
module tb_aq_fadd_vec_seq;

    logic       clk;
    logic       rst;
    logic       reqVld;
    logic       reqRdy;
    logic [1:0] reqSew;
    logic [4:0] reqVl;
    logic [2:0] reqRm;
    logic       flush;
    logic       ex1IssueVld;
    logic [1:0] ex1BeatIdx;
    logic [3:0] ex1ElemMask;
    logic [1:0] ex1Fmt;
    logic       ex2Rne, ex2Rtz, ex2Rdn, ex2Rup, ex2Rmm;
    logic [3:0] ex2Nx;
    logic       wbVld;
    logic [1:0] wbBeatIdx;
    logic       wbLast;
    logic       wbRdy;
    logic       pipeStall;
    logic       busy;
    logic       doneVld;
    logic       doneNx;
    logic       doneIll;
    logic [4:0] ex2Oh;

    int nCompared   = 0;
    int nMismatched = 0;

    assign ex2Oh = {ex2Rmm, ex2Rup, ex2Rdn, ex2Rtz, ex2Rne};

    aq_fadd_vec_seq dut (
        .forever_cpuclk (clk),
        .vfalu_rst      (rst),
        .req_vld        (reqVld),
        .req_rdy        (reqRdy),
        .req_sew        (reqSew),
        .req_vl         (reqVl),
        .req_rm         (reqRm),
        .flush          (flush),
        .ex1_issue_vld  (ex1IssueVld),
        .ex1_beat_idx   (ex1BeatIdx),
        .ex1_elem_mask  (ex1ElemMask),
        .ex1_fmt        (ex1Fmt),
        .ex2_rne        (ex2Rne),
        .ex2_rtz        (ex2Rtz),
        .ex2_rdn        (ex2Rdn),
        .ex2_rup        (ex2Rup),
        .ex2_rmm        (ex2Rmm),
        .ex2_nx         (ex2Nx),
        .wb_vld         (wbVld),
        .wb_beat_idx    (wbBeatIdx),
        .wb_last        (wbLast),
        .wb_rdy         (wbRdy),
        .pipe_stall     (pipeStall),
        .busy           (busy),
        .done_vld       (doneVld),
        .done_nx        (doneNx),
        .done_ill       (doneIll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] sew,
                                 input logic [4:0] vl, input logic [2:0] rm);
        reqVld = vld;
        reqSew = sew;
        reqVl  = vl;
        reqRm  = rm;
    endtask

    // One cycle's view of both pipe stages and the completion outputs.
    task automatic checkBeat(input string tag, input int issue, input int idx, input int mask,
                             input int wv, input int widx, input int wlast,
                             input int dv, input int dnx);
        checkOutput($sformatf("%s.ex1v", tag),  int'(ex1IssueVld), issue);
        checkOutput($sformatf("%s.ex1i", tag),  int'(ex1BeatIdx),  idx);
        checkOutput($sformatf("%s.mask", tag),  int'(ex1ElemMask), mask);
        checkOutput($sformatf("%s.wbv", tag),   int'(wbVld),       wv);
        checkOutput($sformatf("%s.wbi", tag),   int'(wbBeatIdx),   widx);
        checkOutput($sformatf("%s.wbl", tag),   int'(wbLast),      wlast);
        checkOutput($sformatf("%s.done", tag),  int'(doneVld),     dv);
        checkOutput($sformatf("%s.dnx", tag),   int'(doneNx),      dnx);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput($sformatf("%s.busy", tag),  int'(busy),        0);
        checkOutput($sformatf("%s.rdy", tag),   int'(reqRdy),      1);
        checkOutput($sformatf("%s.stall", tag), int'(pipeStall),   0);
        checkOutput($sformatf("%s.rm", tag),    int'(ex2Oh),       0);
        checkOutput($sformatf("%s.ill", tag),   int'(doneIll),     0);
        checkBeat(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        wbRdy = 1'b1;
        ex2Nx = 4'b0000;
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        tick();
        tick();
        settle();
        checkIdle("reset");
        rst = 1'b0;
        tick();

        // Double, vl=3, RNE: three single-lane beats, nx only on beat 1.
        $display("[TB] double vl=3 rne");
        applyStimulus(1'b1, 2'b11, 5'd3, 3'd0);
        settle(); checkOutput("t1.acc.rdy", int'(reqRdy), 1);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t1.c1", 1, 0, 'b0001, 0, 0, 0, 0, 0);
        checkOutput("t1.c1.rm", int'(ex2Oh), 'b00001);
        checkOutput("t1.c1.fmt", int'(ex1Fmt), 3);
        tick();
        settle(); checkBeat("t1.c2", 1, 1, 'b0001, 1, 0, 0, 0, 0); tick();
        ex2Nx = 4'b0001;
        settle(); checkBeat("t1.c3", 1, 2, 'b0001, 1, 1, 0, 0, 0); tick();
        ex2Nx = 4'b0000;
        settle(); checkBeat("t1.c4", 0, 0, 0, 1, 2, 1, 0, 0);
        checkOutput("t1.c4.rm", int'(ex2Oh), 'b00001);
        tick();
        settle(); checkBeat("t1.c5", 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("t1.c5.ill", int'(doneIll), 0);
        tick();
        settle(); checkIdle("t1.c6"); tick();

        // Half, vl=6, RMM: full beat then 0011; nx only in masked-off lanes.
        $display("[TB] half vl=6 rmm");
        applyStimulus(1'b1, 2'b01, 5'd6, 3'd4);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t2.c1", 1, 0, 'b1111, 0, 0, 0, 0, 0);
        checkOutput("t2.c1.rm", int'(ex2Oh), 'b10000);
        tick();
        settle(); checkBeat("t2.c2", 1, 1, 'b0011, 1, 0, 0, 0, 0); tick();
        ex2Nx = 4'b1100;
        settle(); checkBeat("t2.c3", 0, 0, 0, 1, 1, 1, 0, 0); tick();
        ex2Nx = 4'b0000;
        settle(); checkBeat("t2.c4", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        settle(); checkIdle("t2.c5"); tick();

        // Single, vl=8, wb_rdy low in cycles 3-5; nx seen only while stalled.
        $display("[TB] single vl=8 with stall");
        applyStimulus(1'b1, 2'b10, 5'd8, 3'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t3.c1", 1, 0, 'b0011, 0, 0, 0, 0, 0); tick();
        settle(); checkBeat("t3.c2", 1, 1, 'b0011, 1, 0, 0, 0, 0); tick();
        for (int c = 3; c <= 5; c++) begin
            wbRdy = 1'b0;
            ex2Nx = 4'b0010;
            settle();
            checkBeat($sformatf("t3.c%0d", c), 1, 2, 'b0011, 1, 1, 0, 0, 0);
            checkOutput($sformatf("t3.c%0d.stall", c), int'(pipeStall), 1);
            tick();
        end
        wbRdy = 1'b1;
        ex2Nx = 4'b0000;
        settle(); checkBeat("t3.c6", 1, 2, 'b0011, 1, 1, 0, 0, 0);
        checkOutput("t3.c6.stall", int'(pipeStall), 0);
        tick();
        settle(); checkBeat("t3.c7", 1, 3, 'b0011, 1, 2, 0, 0, 0); tick();
        settle(); checkBeat("t3.c8", 0, 0, 0, 1, 3, 1, 0, 0); tick();
        settle(); checkBeat("t3.c9", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        settle(); checkIdle("t3.c10"); tick();

        // Double, vl=4, RDN, flushed in cycle 2, then a clean follow-up.
        $display("[TB] flush mid-request");
        applyStimulus(1'b1, 2'b11, 5'd4, 3'd2);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t4.c1", 1, 0, 'b0001, 0, 0, 0, 0, 0);
        checkOutput("t4.c1.rm", int'(ex2Oh), 'b00100);
        tick();
        flush = 1'b1;
        ex2Nx = 4'b0001;
        settle(); checkBeat("t4.c2", 1, 1, 'b0001, 1, 0, 0, 0, 0); tick();
        flush = 1'b0;
        ex2Nx = 4'b0000;
        settle(); checkIdle("t4.c3");
        applyStimulus(1'b1, 2'b11, 5'd1, 3'd3);
        settle(); checkOutput("t4.c3.rdy2", int'(reqRdy), 1);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t4.c4", 1, 0, 'b0001, 0, 0, 0, 0, 0);
        checkOutput("t4.c4.rm", int'(ex2Oh), 'b01000);
        tick();
        settle(); checkBeat("t4.c5", 0, 0, 0, 1, 0, 1, 0, 0); tick();
        settle(); checkBeat("t4.c6", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        applyStimulus(1'b1, 2'b11, 5'd2, 3'd0);
        flush = 1'b1;
        settle(); checkOutput("t4.fr.rdy", int'(reqRdy), 0);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        flush = 1'b0;
        settle(); checkIdle("t4.fr.next"); tick();

        // vl=0 with legal rm, then an illegal rm.
        $display("[TB] vl=0 and illegal rm");
        applyStimulus(1'b1, 2'b10, 5'd0, 3'd1);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t5.z", 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("t5.z.ill", int'(doneIll), 0);
        checkOutput("t5.z.rm", int'(ex2Oh), 'b00010);
        tick();
        settle(); checkIdle("t5.z.next"); tick();
        applyStimulus(1'b1, 2'b11, 5'd5, 3'd6);
        tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        settle(); checkBeat("t5.i", 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("t5.i.ill", int'(doneIll), 1);
        checkOutput("t5.i.rm", int'(ex2Oh), 0);
        tick();
        settle(); checkIdle("t5.i.next"); tick();

        // Reset mid-ISSUE with req_vld held; vl=16 double clamps to 4 beats.
        $display("[TB] reset mid-issue");
        applyStimulus(1'b1, 2'b11, 5'd16, 3'd0);
        tick();
        settle(); checkBeat("t6.c1", 1, 0, 'b0001, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        tick();
        settle(); checkIdle("t6.c3"); tick();
        rst = 1'b0;
        settle(); checkIdle("t6.c4"); tick();
        applyStimulus(1'b0, 2'b00, 5'd0, 3'd0);
        for (int b = 0; b < 4; b++) begin
            settle();
            checkBeat($sformatf("t6.b%0d", b), 1, b, 'b0001, (b > 0) ? 1 : 0,
                      (b > 0) ? b - 1 : 0, 0, 0, 0);
            tick();
        end
        settle(); checkBeat("t6.last", 0, 0, 0, 1, 3, 1, 0, 0); tick();
        settle(); checkBeat("t6.done", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        settle(); checkIdle("t6.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
